// File: rtl/risc_pkg.sv
// Shared types for the 16-bit RISC pipeline: datapath widths, the memory-port
// state encoding and the control bits carried through EX/MEM.
package risc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } exmem_ctrl_t;

  // A read that also writes is handled as a store, so it returns no load data.
  function automatic logic is_load(exmem_ctrl_t c);
    return c.mem_read & ~c.mem_write;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
interface memory_access_if #(
  parameter int DATA_W = risc_pkg::DATA_W
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/dmem_port_fsm.sv
// Req/ack state machine for data memory with address/data/we hold registers.
// MEM_ACCESS_TIMEOUT_EN adds a watchdog that aborts an access left unacknowledged.
module dmem_port_fsm #(
  parameter int DATA_W         = risc_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  we_i,
  input  logic [DATA_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  memory_access_if.master       dmem,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  abort_o,
  output logic [DATA_W-1:0]     rdata_o
);
  import risc_pkg::*;

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              we_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog_limit
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        we_q    <= we_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    abort_o = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE: if (start_i) state_d = BUSY;
      BUSY: begin
        if (dmem.dmem_ack) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        // Ack wins over the watchdog when both land on the same edge.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort_o = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o          = (state_q == BUSY);
  assign dmem.dmem_req   = busy_o;
  assign dmem.dmem_we    = we_q & busy_o;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign rdata_o         = dmem.dmem_rdata;

endmodule

// File: rtl/memory_access.sv
// Memory stage: EX/MEM register, branch resolution, data-memory access and the
// registered MEM/WB bundle. MEM_ACCESS_TIMEOUT_EN enables the ack watchdog and mem_fault.
module memory_access #(
  parameter int DATA_W         = risc_pkg::DATA_W,
  parameter int REG_W          = risc_pkg::REG_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [DATA_W-1:0] adder_result,
  input  logic              Zero,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [REG_W-1:0]  mux_rd_rt_out,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  output logic              mem_stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] branch_target,
  memory_access_if.master   dmem,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_rd
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  output logic              mem_fault
`endif
);
  import risc_pkg::*;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  rd;
  } wb_t;

  exmem_ctrl_t       ctrl_in, ctrl_q;
  logic [DATA_W-1:0] alu_q, tgt_q;
  logic [REG_W-1:0]  rd_q;
  logic              zero_q, fresh_q;
  wb_t               wb_d, wb_q;
  logic              busy, done, abort, capture, is_mem;
  logic [DATA_W-1:0] rdata;

  assign ctrl_in = '{branch:     Branch_in,
                     mem_read:   MemRead_in,
                     mem_write:  MemWrite_in,
                     reg_write:  RegWrite_in,
                     mem_to_reg: MemtoReg_in};

  assign is_mem    = MemRead_in | MemWrite_in;
  assign capture   = ex_valid & ~busy;
  assign mem_stall = busy;

  dmem_port_fsm #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (capture & is_mem),
    .we_i    (MemWrite_in),
    .addr_i  (ALU_Result),
    .wdata_i (read_data_2),
    .dmem    (dmem),
    .busy_o  (busy),
    .done_o  (done),
    .abort_o (abort),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      tgt_q   <= '0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      fresh_q <= capture;
      if (capture) begin
        ctrl_q <= ctrl_in;
        alu_q  <= ALU_Result;
        tgt_q  <= adder_result;
        rd_q   <= mux_rd_rt_out;
        zero_q <= Zero;
      end
    end
  end

  // fresh_q limits the branch decision to the cycle right after capture.
  assign PCSrc         = fresh_q & ctrl_q.branch & zero_q;
  assign branch_target = tgt_q;

  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    if (capture && !is_mem) begin
      wb_d.valid      = 1'b1;
      wb_d.reg_write  = RegWrite_in;
      wb_d.mem_to_reg = MemtoReg_in;
      wb_d.read_data  = '0;
      wb_d.alu_result = ALU_Result;
      wb_d.rd         = mux_rd_rt_out;
    end else if (done || abort) begin
      // An aborted access retires with RegWrite cleared so nothing is written back.
      wb_d.valid      = 1'b1;
      wb_d.reg_write  = ctrl_q.reg_write & ~abort;
      wb_d.mem_to_reg = ctrl_q.mem_to_reg;
      wb_d.read_data  = (done && is_load(ctrl_q)) ? rdata : '0;
      wb_d.alu_result = alu_q;
      wb_d.rd         = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wb_q <= '0;
    else        wb_q <= wb_d;
  end

  assign wb_valid      = wb_q.valid;
  assign wb_RegWrite   = wb_q.reg_write;
  assign wb_MemtoReg   = wb_q.mem_to_reg;
  assign wb_read_data  = wb_q.read_data;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_rd         = wb_q.rd;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     fault_q <= 1'b0;
    else if (abort) fault_q <= 1'b1;
  end

  assign mem_fault = fault_q;
`endif

endmodule
